// File: rtl/kd_tree_pkg.sv
// Shared definitions for the kd-tree node command interface and the root center loader.
package kd_tree_pkg;

    localparam int unsigned COMMAND_SIZE = 5;
    localparam int unsigned DATA_SIZE    = 24;

    localparam logic [COMMAND_SIZE-1:0] CmdNop            = 5'b00000;
    localparam logic [COMMAND_SIZE-1:0] CmdRst            = 5'b11111;
    localparam logic [COMMAND_SIZE-1:0] CmdRstDone        = 5'b11110;
    localparam logic [COMMAND_SIZE-1:0] CmdCenterFill     = 5'b00001;
    localparam logic [COMMAND_SIZE-1:0] CmdCenterFillDone = 5'b00101;
    localparam logic [COMMAND_SIZE-1:0] CmdBusy           = 5'b01000;
    // Part of the node command set; the loader never issues or expects it.
    localparam logic [COMMAND_SIZE-1:0] CmdDne            = 5'b00010;

    typedef enum logic [2:0] {
        StIdle,
        StRstIssue,
        StFill,
        StWaitFill,
        StDone,
        StError
    } loader_state_e;

endpackage

// File: rtl/kd_tree_timeout_timer.sv
// Cycle counter that flags expiry on the TIMEOUT_CYCLES-th enabled cycle after a clear.
module kd_tree_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TW-1:0] LastCount = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [TW-1:0] count_q, count_d;

    // A zero timeout never expires.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_q == LastCount);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/kd_tree_center_loader.sv
// Sequences the kd-tree root through reset, a NUM_CENTERS center fill from a valid/ready
// source, and the fill-done handshake; reports done, or error if the root stops answering.
module kd_tree_center_loader
    import kd_tree_pkg::*;
#(
    parameter int unsigned NUM_CENTERS    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned CntW = $clog2(NUM_CENTERS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    center_valid,
    input  logic [DATA_SIZE-1:0]    center_data,
    output logic                    center_ready,
    input  logic [COMMAND_SIZE-1:0] command_from_root,
    output logic [COMMAND_SIZE-1:0] command_to_root,
    output logic [DATA_SIZE-1:0]    data_to_root,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [CntW-1:0]         centers_sent
);

    loader_state_e           state_q, state_d;
    logic [COMMAND_SIZE-1:0] cmd_q, cmd_d;
    logic [DATA_SIZE-1:0]    data_q, data_d;
    logic [CntW-1:0]         sent_q, sent_d;
    logic                    handshake;
    logic                    timer_en, timer_clear, timer_expired;

    assign center_ready = (state_q == StFill) && (command_from_root != CmdBusy)
                          && (sent_q < CntW'(NUM_CENTERS));
    assign handshake    = center_valid && center_ready;

    // Timer restarts on every state change and only runs while waiting on the root.
    assign timer_en    = (state_q == StRstIssue) || (state_q == StWaitFill);
    assign timer_clear = (state_d != state_q) || !timer_en;

    kd_tree_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StRstIssue;
                    sent_d  = '0;
                end
            end
            // A response on the expiry cycle takes priority over the timeout.
            StRstIssue: begin
                if (command_from_root == CmdRstDone) begin
                    state_d = StFill;
                end else if (timer_expired) begin
                    state_d = StError;
                end
            end
            StFill: begin
                if (handshake) begin
                    sent_d = sent_q + 1'b1;
                    if (sent_q == CntW'(NUM_CENTERS - 1)) begin
                        state_d = StWaitFill;
                    end
                end
            end
            StWaitFill: begin
                if (command_from_root == CmdCenterFillDone) begin
                    state_d = StDone;
                end else if (timer_expired) begin
                    state_d = StError;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output stage is registered: commands reflect the state being entered.
    always_comb begin
        cmd_d  = (state_d == StRstIssue) ? CmdRst : CmdNop;
        data_d = data_q;
        if (handshake) begin
            cmd_d  = CmdCenterFill;
            data_d = center_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cmd_q   <= CmdNop;
            data_q  <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
        end
    end

    assign command_to_root = cmd_q;
    assign data_to_root    = data_q;
    assign centers_sent    = sent_q;
    assign busy  = (state_q == StRstIssue) || (state_q == StFill) || (state_q == StWaitFill);
    assign done  = (state_q == StDone);
    assign error = (state_q == StError);

endmodule

// File: tb/tb_kd_tree_center_loader.sv
// Self-checking bench for kd_tree_center_loader: decode table plus scripted runs with a
// scoreboard matching accepted centers against center_fill cycles seen at the root.
module tb_kd_tree_center_loader;
    import kd_tree_pkg::*;

    localparam int unsigned NumCenters = 10;
    localparam int unsigned Timeout    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        center_valid;
    logic [23:0] center_data;
    logic        center_ready;
    logic [4:0]  command_from_root;
    logic [4:0]  command_to_root;
    logic [23:0] data_to_root;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  centers_sent;

    int          errors = 0;
    int          checks = 0;
    int          fills  = 0;
    int          n_rst;
    logic [23:0] exp_q[$];

    typedef struct {
        logic [4:0]  root_cmd;
        logic        valid;
        logic [23:0] data;
        logic        exp_ready;
        logic [4:0]  exp_cmd;
        logic [23:0] exp_data;
        logic [3:0]  exp_sent;
    } vec_t;

    vec_t vecs[10];

    kd_tree_center_loader #(
        .NUM_CENTERS   (NumCenters),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .center_valid     (center_valid),
        .center_data      (center_data),
        .center_ready     (center_ready),
        .command_from_root(command_from_root),
        .command_to_root  (command_to_root),
        .data_to_root     (data_to_root),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .centers_sent     (centers_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: an accepted center must appear as exactly one center_fill, in order.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (command_to_root == CmdCenterFill) begin
                fills++;
                if (exp_q.size() == 0) begin
                    check("unexpected_center_fill", 32'(data_to_root), 32'hFFFF_FFFF);
                end else begin
                    check("fill_data", 32'(data_to_root), 32'(exp_q.pop_front()));
                end
            end
            if (center_valid && center_ready) exp_q.push_back(center_data);
        end
    end

    // Pulse start, count cycles of rst at the root, answer rst_done after answer_after (0 = never).
    task automatic start_run(input int answer_after, output int n);
        int guard;
        n = 0;
        guard = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (command_to_root == CmdRst && guard < 100) begin
            n++;
            guard++;
            if (answer_after != 0 && n == answer_after) command_from_root = CmdRstDone;
            tick();
            command_from_root = CmdNop;
        end
    endtask

    // Source model: offers centers first..last, holding each until accepted.
    task automatic stream(input int first, input int last, input int busy_after,
                          input int start_at);
        int   nxt;
        int   busy_left;
        int   guard;
        logic hs;
        nxt = first;
        busy_left = 0;
        guard = 0;
        while (nxt <= last && guard < 200) begin
            guard++;
            center_valid = 1'b1;
            center_data = 24'(nxt);
            command_from_root = (busy_left > 0) ? CmdBusy : CmdNop;
            start = (nxt == start_at);
            #1;
            hs = center_ready;
            if (busy_left > 0) begin
                check("ready_while_root_busy", 32'(center_ready), 32'd0);
                busy_left--;
            end
            tick();
            start = 1'b0;
            if (hs) begin
                if (nxt == busy_after) busy_left = 4;
                nxt++;
            end
        end
        center_valid = 1'b0;
        command_from_root = CmdNop;
        check("stream_complete", 32'(nxt), 32'(last + 1));
    endtask

    // Called one cycle after the last handshake; root answers fill_done on WAIT cycle resp_cycle.
    task automatic finish_run(input int resp_cycle, input string tag);
        check({tag, "_last_fill_cmd"}, 32'(command_to_root), 32'(CmdCenterFill));
        check({tag, "_last_fill_data"}, 32'(data_to_root), 32'd10);
        check({tag, "_sent"}, 32'(centers_sent), 32'd10);
        check({tag, "_ready_after_last"}, 32'(center_ready), 32'd0);
        tick();
        check({tag, "_nop_after_last"}, 32'(command_to_root), 32'(CmdNop));
        check({tag, "_busy_waiting"}, 32'(busy), 32'd1);
        repeat (resp_cycle - 1) tick();
        command_from_root = CmdCenterFillDone;
        tick();
        command_from_root = CmdNop;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_fill_count"}, 32'(fills), 32'd10);
        check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        //           root_cmd           vld data   rdy exp_cmd        data  sent
        vecs[0] = '{CmdNop,            0, 24'h0,  1, CmdNop,        24'h0, 4'd0};
        vecs[1] = '{CmdBusy,           1, 24'hAA, 0, CmdNop,        24'h0, 4'd0};
        vecs[2] = '{CmdRstDone,        0, 24'h0,  1, CmdNop,        24'h0, 4'd0};
        vecs[3] = '{CmdCenterFillDone, 0, 24'h0,  1, CmdNop,        24'h0, 4'd0};
        vecs[4] = '{CmdNop,            1, 24'h1,  1, CmdCenterFill, 24'h1, 4'd1};
        vecs[5] = '{CmdNop,            1, 24'h2,  1, CmdCenterFill, 24'h2, 4'd2};
        vecs[6] = '{CmdCenterFillDone, 1, 24'h3,  1, CmdCenterFill, 24'h3, 4'd3};
        vecs[7] = '{CmdBusy,           1, 24'h4,  0, CmdNop,        24'h3, 4'd3};
        vecs[8] = '{CmdBusy,           0, 24'h4,  0, CmdNop,        24'h3, 4'd3};
        vecs[9] = '{CmdRstDone,        1, 24'h4,  1, CmdCenterFill, 24'h4, 4'd4};

        reset = 1'b1;
        start = 1'b0;
        center_valid = 1'b0;
        center_data = '0;
        command_from_root = CmdNop;
        tick();
        check("rst_cmd", 32'(command_to_root), 32'(CmdNop));
        check("rst_data", 32'(data_to_root), 32'd0);
        check("rst_ready", 32'(center_ready), 32'd0);
        check("rst_flags", {29'd0, busy, done, error}, 32'd0);
        check("rst_sent", 32'(centers_sent), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Run A: rst_done after 3 cycles, decode table, then 5..10 with a start while busy.
        fills = 0;
        start_run(3, n_rst);
        check("a_rst_cycles", 32'(n_rst), 32'd3);
        check("a_fill_cmd_nop", 32'(command_to_root), 32'(CmdNop));
        for (int i = 0; i < 10; i++) begin
            command_from_root = vecs[i].root_cmd;
            center_valid = vecs[i].valid;
            center_data = vecs[i].data;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(center_ready), 32'(vecs[i].exp_ready));
            tick();
            check($sformatf("vec%0d_cmd", i), 32'(command_to_root), 32'(vecs[i].exp_cmd));
            check($sformatf("vec%0d_data", i), 32'(data_to_root), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_sent", i), 32'(centers_sent), 32'(vecs[i].exp_sent));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
        end
        stream(5, 10, 0, 7);
        finish_run(2, "a");

        // Run B: restart from DONE, root busy for 4 cycles after center 5.
        fills = 0;
        start_run(3, n_rst);
        check("b_rst_cycles", 32'(n_rst), 32'd3);
        check("b_done_cleared", 32'(done), 32'd0);
        check("b_sent_cleared", 32'(centers_sent), 32'd0);
        stream(1, 10, 5, 0);
        finish_run(2, "b");

        // Run C: rst_done never arrives, error after exactly Timeout rst cycles.
        start_run(0, n_rst);
        check("c_rst_cycles", 32'(n_rst), 32'(Timeout));
        check("c_error", 32'(error), 32'd1);
        check("c_busy", 32'(busy), 32'd0);
        check("c_cmd_nop", 32'(command_to_root), 32'(CmdNop));
        tick();
        check("c_error_held", 32'(error), 32'd1);

        // Recover from ERROR, then reset while center 5 is offered after center 4 was sent.
        fills = 0;
        start_run(3, n_rst);
        check("d_rst_cycles", 32'(n_rst), 32'd3);
        check("d_error_cleared", 32'(error), 32'd0);
        stream(1, 4, 0, 0);
        center_valid = 1'b1;
        center_data = 24'd5;
        #1;
        reset = 1'b1;
        #1;
        check("d_async_cmd", 32'(command_to_root), 32'(CmdNop));
        check("d_async_data", 32'(data_to_root), 32'd0);
        check("d_async_sent", 32'(centers_sent), 32'd0);
        check("d_async_ready", 32'(center_ready), 32'd0);
        check("d_async_busy", 32'(busy), 32'd0);
        tick();
        center_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Fresh run; fill_done lands on the same cycle the wait timer would expire.
        fills = 0;
        start_run(3, n_rst);
        check("e_rst_cycles", 32'(n_rst), 32'd3);
        stream(1, 10, 0, 0);
        finish_run(Timeout - 1, "e");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
